// File: rtl/time_display_pkg.sv
// Shared constants, types and the seven-segment encoder for the song-timer display.
package time_display_pkg;

  localparam int unsigned BIN_W = 6;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [BIN_W-1:0] MAX_TIME = 6'd59;

  // {g,f,e,d,c,b,a}, active-low
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    CONV_IDLE,
    CONV_BUSY
  } conv_state_e;

  typedef struct packed {
    logic [BCD_W-1:0] m_tens;
    logic [BCD_W-1:0] m_ones;
    logic [BCD_W-1:0] s_tens;
    logic [BCD_W-1:0] s_ones;
  } digits_t;

  typedef struct packed {
    logic             ss;
    logic [BIN_W-1:0] mins1;
    logic [BIN_W-1:0] secs1;
    logic [BIN_W-1:0] mins2;
    logic [BIN_W-1:0] secs2;
  } snap_t;

  function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_W-1:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/time_display_bin2bcd.sv
// Saturating 6-bit binary to two-digit BCD converter using repeated subtraction of ten.
module time_display_bin2bcd
  import time_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [BIN_W-1:0] bin_i,
  output logic             done_o,
  output logic [BCD_W-1:0] tens_o,
  output logic [BCD_W-1:0] ones_o
);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BIN_W-1:0] rem_q, rem_d;
  logic [BCD_W-1:0] tens_q, tens_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rem_q  <= '0;
      tens_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      rem_q  <= rem_d;
      tens_q <= tens_d;
    end
  end

  // done is raised on the same edge that leaves the remainder below ten
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    rem_d  = rem_q;
    tens_d = tens_q;
    if (start_i) begin
      rem_d  = (bin_i > MAX_TIME) ? MAX_TIME : bin_i;
      tens_d = '0;
      if (rem_d < 6'd10) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        busy_d = 1'b1;
      end
    end else if (busy_q) begin
      rem_d  = rem_q - 6'd10;
      tens_d = tens_q + 4'd1;
      if (rem_d < 6'd10) begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
    end
  end

  assign done_o = done_q;
  assign tens_o = tens_q;
  assign ones_o = rem_q[BCD_W-1:0];

endmodule

// File: rtl/time_display.sv
// Song-timer reader: synchronises the timer values, converts the active song to BCD and
// drives a multiplexed MM.SS seven-segment display that blinks while paused.
module time_display
  import time_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       RESET_N,
  input  logic       ss,
  input  logic       ispaused,
  input  logic [5:0] mins1,
  input  logic [5:0] secs1,
  input  logic [5:0] mins2,
  input  logic [5:0] secs2,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned SYNC_W = 26;
  localparam int unsigned DATA_W = 25;
  localparam int unsigned RW     = $clog2(REFRESH_DIV);
  localparam int unsigned BW     = $clog2(BLINK_DIV);

  logic [SYNC_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0] prev_q;
  snap_t             snap_q;
  logic              paused_s;

  // Two-flop synchroniser plus a stability filter against skew across the 26 bits
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      snap_q  <= '0;
    end else begin
      sync1_q <= {ispaused, ss, mins1, secs1, mins2, secs2};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q[DATA_W-1:0];
      if (sync2_q[DATA_W-1:0] == prev_q) snap_q <= snap_t'(sync2_q[DATA_W-1:0]);
    end
  end

  assign paused_s = sync2_q[SYNC_W-1];

  logic [BIN_W-1:0] sel_min, sel_sec;
  assign sel_min = snap_q.ss ? snap_q.mins2 : snap_q.mins1;
  assign sel_sec = snap_q.ss ? snap_q.secs2 : snap_q.secs1;

  logic             start_c;
  logic             min_done, sec_done;
  logic [BCD_W-1:0] min_tens, min_ones, sec_tens, sec_ones;

  time_display_bin2bcd u_min_conv (
    .clk     (clk),
    .rst_n   (RESET_N),
    .start_i (start_c),
    .bin_i   (sel_min),
    .done_o  (min_done),
    .tens_o  (min_tens),
    .ones_o  (min_ones)
  );

  time_display_bin2bcd u_sec_conv (
    .clk     (clk),
    .rst_n   (RESET_N),
    .start_i (start_c),
    .bin_i   (sel_sec),
    .done_o  (sec_done),
    .tens_o  (sec_tens),
    .ones_o  (sec_ones)
  );

  conv_state_e      state_q, state_d;
  logic             min_got_q, min_got_d, sec_got_q, sec_got_d;
  logic [BIN_W-1:0] cmin_q, cmin_d, csec_q, csec_d;
  logic [BIN_W-1:0] pmin_q, pmin_d, psec_q, psec_d;
  digits_t          digits_q, digits_d;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= CONV_IDLE;
      min_got_q <= 1'b0;
      sec_got_q <= 1'b0;
      cmin_q    <= '0;
      csec_q    <= '0;
      pmin_q    <= '0;
      psec_q    <= '0;
      digits_q  <= '0;
    end else begin
      state_q   <= state_d;
      min_got_q <= min_got_d;
      sec_got_q <= sec_got_d;
      cmin_q    <= cmin_d;
      csec_q    <= csec_d;
      pmin_q    <= pmin_d;
      psec_q    <= psec_d;
      digits_q  <= digits_d;
    end
  end

  // Committed values track the raw request so a source change always re-converts
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    min_got_d = min_got_q;
    sec_got_d = sec_got_q;
    cmin_d    = cmin_q;
    csec_d    = csec_q;
    pmin_d    = pmin_q;
    psec_d    = psec_q;
    digits_d  = digits_q;
    case (state_q)
      CONV_IDLE: begin
        if ((sel_min != cmin_q) || (sel_sec != csec_q)) begin
          start_c   = 1'b1;
          pmin_d    = sel_min;
          psec_d    = sel_sec;
          min_got_d = 1'b0;
          sec_got_d = 1'b0;
          state_d   = CONV_BUSY;
        end
      end
      CONV_BUSY: begin
        min_got_d = min_got_q | min_done;
        sec_got_d = sec_got_q | sec_done;
        if (min_got_d && sec_got_d) begin
          digits_d.m_tens = min_tens;
          digits_d.m_ones = min_ones;
          digits_d.s_tens = sec_tens;
          digits_d.s_ones = sec_ones;
          cmin_d          = pmin_q;
          csec_d          = psec_q;
          state_d         = CONV_IDLE;
        end
      end
      default: state_d = CONV_IDLE;
    endcase
  end

  logic [RW-1:0]    refresh_q, refresh_d;
  logic [1:0]       idx_q, idx_d;
  logic [BW-1:0]    blink_q, blink_d;
  logic             phase_q, phase_d;
  logic [3:0]       an_q, an_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [BCD_W-1:0] dig;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      refresh_q <= '0;
      idx_q     <= '0;
      blink_q   <= '0;
      phase_q   <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      refresh_q <= refresh_d;
      idx_q     <= idx_d;
      blink_q   <= blink_d;
      phase_q   <= phase_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
    end
  end

  // Outputs are built from next-state index and digits so a commit shows without lag
  always_comb begin
    refresh_d = refresh_q + RW'(1);
    idx_d     = idx_q;
    if (refresh_q == RW'(REFRESH_DIV - 1)) begin
      refresh_d = '0;
      idx_d     = idx_q + 2'd1;
    end
    blink_d = '0;
    phase_d = 1'b0;
    if (paused_s) begin
      blink_d = blink_q + BW'(1);
      phase_d = phase_q;
      if (blink_q == BW'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end
    end
    case (idx_d)
      2'd3:    dig = digits_d.m_tens;
      2'd2:    dig = digits_d.m_ones;
      2'd1:    dig = digits_d.s_tens;
      default: dig = digits_d.s_ones;
    endcase
    an_d  = phase_d ? 4'b1111 : ~(4'b0001 << idx_d);
    seg_d = seg_encode(dig);
    dp_d  = (idx_d != 2'd2);
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_time_display.sv
// Scoreboarded random/directed bench for time_display with a small reference display model.
module tb_time_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLINK_DIV   = 8;
  localparam int SETTLE      = 14;
  localparam int TIMEOUT     = 60;

  logic       clk, RESET_N, ss, ispaused;
  logic [5:0] mins1, secs1, mins2, secs2;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  logic [15:0] q[$];

  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  time_display #(.REFRESH_DIV(REFRESH_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk      (clk),
    .RESET_N  (RESET_N),
    .ss       (ss),
    .ispaused (ispaused),
    .mins1    (mins1),
    .secs1    (secs1),
    .mins2    (mins2),
    .secs2    (secs2),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: saturate to 59 and split into decimal digits {mm_t, mm_o, ss_t, ss_o}
  function automatic logic [15:0] expect_disp(input int m, input int s);
    int mm, sv;
    mm = (m > 59) ? 59 : m;
    sv = (s > 59) ? 59 : s;
    return {4'(mm / 10), 4'(mm % 10), 4'(sv / 10), 4'(sv % 10)};
  endfunction

  function automatic int pos_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic drive(input bit s, input int m1, input int s1, input int m2, input int s2);
    ss    = s;
    mins1 = 6'(m1);
    secs1 = 6'(s1);
    mins2 = 6'(m2);
    secs2 = 6'(s2);
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) break;
      @(posedge clk);
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d items left, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic issue(input bit s, input int m1, input int s1, input int m2, input int s2);
    @(posedge clk);
    #1;
    drive(s, m1, s1, m2, s2);
    q.push_back(s ? expect_disp(m2, s2) : expect_disp(m1, s1));
    drain();
  endtask

  // Monitor: collects one full scan after settling, and checks every transient digit
  initial begin
    logic [15:0] prev, cur;
    logic [6:0]  got_seg [4];
    logic        got_dp  [4];
    logic [3:0]  seen;
    int          age, p;
    bit          transit_bad;
    prev = '0; seen = '0; age = 0; transit_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (!RESET_N) begin
        prev = '0; seen = '0; age = 0; transit_bad = 1'b0;
      end else if (q.size() > 0) begin
        cur = q[0];
        age++;
        p = pos_of(an);
        if (p >= 0) begin
          if (seg != seg_tbl[prev[p*4 +: 4]] && seg != seg_tbl[cur[p*4 +: 4]]) transit_bad = 1'b1;
          if (age >= SETTLE) begin
            got_seg[p] = seg;
            got_dp[p]  = dp;
            seen[p]    = 1'b1;
          end
        end
        if (seen == 4'hF || age > TIMEOUT) begin
          chk("scan_complete", 32'(seen), 32'hF);
          for (int i = 0; i < 4; i++)
            chk($sformatf("digit%0d", i), 32'(got_seg[i]), 32'(seg_tbl[cur[i*4 +: 4]]));
          chk("dp_pattern", 32'({got_dp[3], got_dp[2], got_dp[1], got_dp[0]}), 32'b1011);
          chk("no_stale_mix", 32'(transit_bad), 32'd0);
          void'(q.pop_front());
          prev = cur; seen = '0; age = 0; transit_bad = 1'b0;
          for (int i = 0; i < 4; i++) begin got_seg[i] = '0; got_dp[i] = 1'b0; end
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_an;
    int         idx;
    bit         exp_blank;
    RESET_N  = 1'b1;
    ispaused = 1'b0;
    drive(0, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    repeat (3) @(posedge clk);
    #1 RESET_N = 1'b1;

    issue(0, 12, 34, 0, 0);

    // Reset while a conversion is in flight and the scan is running
    @(posedge clk);
    #1 drive(0, 45, 50, 0, 0);
    repeat (7) @(posedge clk);
    #1 drive(0, 0, 0, 0, 0);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_seg", 32'(seg), 32'h7F);
    chk("midrst_dp", 32'(dp), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 RESET_N = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      idx    = (k / REFRESH_DIV) % 4;
      exp_an = ~(4'(1) << idx);
      chk($sformatf("post_rst_an%0d", k), 32'(an), 32'(exp_an));
      chk($sformatf("post_rst_seg%0d", k), 32'(seg), 32'(seg_tbl[0]));
      chk($sformatf("post_rst_dp%0d", k), 32'(dp), (idx == 2) ? 32'd0 : 32'd1);
    end

    issue(0, 12, 34, 0, 0);
    @(posedge clk);
    #1 drive(0, 12, 34, 59, 7);
    repeat (20) @(posedge clk);
    issue(1, 12, 34, 59, 7);
    issue(0, 63, 60, 59, 7);
    issue(0, 0, 31, 0, 0);

    // secs1 31 -> 32 with bit 0 falling one cycle late
    @(posedge clk);
    #1 secs1 = 6'b100001;
    q.push_back(expect_disp(0, 32));
    @(posedge clk);
    #1 secs1 = 6'b100000;
    drain();

    for (int n = 0; n < 30; n++)
      issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));

    // Blink: pause is seen two edges after it is driven
    @(posedge clk);
    #1 ispaused = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_blank = (k >= 2) && ((((k - 2) / BLINK_DIV) % 2) == 1);
      chk($sformatf("blink%0d", k), 32'(an == 4'hF), 32'(exp_blank));
    end
    ispaused = 1'b0;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("unpause%0d", k), 32'(an == 4'hF), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_display.md
Name: time_display

Overview:
- Reader side of the song-timer counter.
- Takes the two binary mins/secs pairs plus the song-select and pause flags, picks the active song, and converts minutes and seconds to BCD.
- Drives a 4-digit multiplexed active-low seven-segment display (MM.SS) and blinks the display while paused.
- Sits between the 1 Hz timer block and the board display pins; runs on the fast board clock.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit; must be ≥2.
- BLINK_DIV, 25000000, clk cycles per blink half-period while paused; must be ≥2.

Ports:
- clk  in  1  board clock; the only clock.
- RESET_N  in  1  asynchronous, active-low reset.
- ss  in  1  song select: 0 = song 1, 1 = song 2.
- ispaused  in  1  1 = paused (display blinks).
- mins1  in  6  song 1 minutes, binary.
- secs1  in  6  song 1 seconds, binary.
- mins2  in  6  song 2 minutes, binary.
- secs2  in  6  song 2 seconds, binary.
- an  out  4  digit enables, active-low; an[3] = mins tens … an[0] = secs ones.
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; lit only on the an[2] digit (colon substitute).

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - Digit registers = 0; scan index = 0; all counters = 0; blink phase = 0; converters idle.
- Input capture:
  - All inputs (26 bits) pass through a 2-flop synchronizer.
  - A snapshot is accepted only when stage-2 equals the previous stage-2 value (stable for 2 consecutive cycles). This rejects multi-bit skew from the 1 Hz domain.
- Source select:
  - Synchronized ss=0 selects mins1/secs1; ss=1 selects mins2/secs2.
  - Values >59 saturate to 59 before conversion.
- Conversion: two bin2bcd instances (minutes, seconds) with a start/done handshake.
  - Start is issued when converters are idle and the stable snapshot differs from the last committed value.
  - Cycle 1: load. Each following cycle: if remainder ≥10, subtract 10 and increment tens.
  - done pulses 1 cycle when remainder <10. Latency = 1 + tens cycles, max 6.
  - Both done → commit the 4 digit registers next cycle; a new start is allowed the cycle after commit.
  - Input change to committed digits ≤12 clk cycles.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1. At terminal count it wraps and the 2-bit index advances 0→1→2→3→0.
  - an, seg and dp are registered from the index and digit registers, so all three change in the same cycle.
  - Index i drives an[i] low and seg = encode(digit[i]).
- Blink:
  - While synchronized ispaused=1: blink counter counts 0..BLINK_DIV-1 and toggles phase at wrap.
  - Phase=1 forces an=4'b1111 (seg/dp don't care); the scan keeps running.
  - When ispaused=0: blink counter and phase clear in the next cycle and the display is on.
  - The first blank occurs BLINK_DIV cycles after pause is seen.
- Boundary cases:
  - ss toggles mid-conversion: the conversion in flight completes and commits. The new source is then detected as changed and converted, so a stale value shows ≤12 cycles.
  - Reset mid-conversion: aborts immediately.
  - Simultaneous refresh wrap and commit: the scan uses the new digits.

Decomposition:
- Package time_display_pkg:
  - SEG_0..SEG_9 encodings: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - SEG_BLANK = 1111111.
  - MAX_TIME = 59.
- Sub-module bin2bcd (6-bit in, 4-bit tens/ones out, start/done, saturating); instantiated twice.

Test Plan:
- Reset asserted mid-scan → an=1111, seg=1111111, dp=1 immediately. After release with ss=0, mins1=0, secs1=0 and REFRESH_DIV=4 → digits 0,0,0,0 scan an 1110→1101→1011→0111, every 4 cycles.
- ss=0, mins1=12, secs1=34 → within 12 cycles: an[3]→SEG_1, an[2]→SEG_2 with dp=0, an[1]→SEG_3, an[0]→SEG_4.
- ss 0→1 with mins2=59, secs2=7 → digits become 5,9,0,7 within 12 cycles; no intermediate mix of song 1 and song 2 values.
- mins1=63, secs1=60 → displays 59:59 (saturation).
- ispaused=1 with BLINK_DIV=8 → an=1111 for 8 cycles, normal scan for 8 cycles, repeating. ispaused=0 → display on within 3 cycles (sync plus clear).
- secs1 changes 6'b011111→6'b100000 with one bit skewed by one cycle → glitch value never committed; final digits 3,2.
